// File: rtl/character_drawer.sv
// Redraws the player sprite on the VGA pixel bus whenever the slot position changes.
// The old slot is erased with the background colour, then the new slot is drawn, one pixel per clock.
module character_drawer #(
    parameter int unsigned SPRITE_W    = 8,
    parameter int unsigned SPRITE_H    = 8,
    parameter int unsigned X_ORIGIN    = 8,
    parameter int unsigned X_STEP      = 16,
    parameter int unsigned Y_ROW       = 104,
    parameter logic [2:0]  CHAR_COLOUR = 3'b110,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [3:0] CurrState,
    output logic [7:0] X,
    output logic [6:0] Y,
    output logic [2:0] Colour,
    output logic       Plot,
    output logic       Busy
);

    localparam int unsigned ColW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
    localparam int unsigned RowW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
    localparam logic [ColW-1:0] LastCol = ColW'(SPRITE_W - 1);
    localparam logic [RowW-1:0] LastRow = RowW'(SPRITE_H - 1);
    localparam logic [3:0] MaxSlot = 4'd8;

    typedef enum logic [1:0] {StIdle, StErase, StDraw} drawState;

    drawState        state, stateNext;
    logic [ColW-1:0] col, colNext;
    logic [RowW-1:0] row, rowNext;
    logic [3:0]      targetPos, targetPosNext;
    logic [3:0]      oldPos, oldPosNext;
    logic [3:0]      drawnPos, drawnPosNext;
    logic            drawnValid, drawnValidNext;
    logic [7:0]      xNext;
    logic [6:0]      yNext;
    logic [2:0]      colourNext;
    logic            plotNext;
    logic [3:0]      slot;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= StIdle;
            col        <= '0;
            row        <= '0;
            targetPos  <= '0;
            oldPos     <= '0;
            drawnPos   <= '0;
            drawnValid <= 1'b0;
            X          <= '0;
            Y          <= '0;
            Colour     <= '0;
            Plot       <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            state      <= stateNext;
            col        <= colNext;
            row        <= rowNext;
            targetPos  <= targetPosNext;
            oldPos     <= oldPosNext;
            drawnPos   <= drawnPosNext;
            drawnValid <= drawnValidNext;
            X          <= xNext;
            Y          <= yNext;
            Colour     <= colourNext;
            Plot       <= plotNext;
            Busy       <= plotNext;
        end
    end

    always_comb begin
        stateNext      = state;
        colNext        = col;
        rowNext        = row;
        targetPosNext  = targetPos;
        oldPosNext     = oldPos;
        drawnPosNext   = drawnPos;
        drawnValidNext = drawnValid;

        unique case (state)
            StIdle: begin
                if (CurrState <= MaxSlot && (!drawnValid || CurrState != drawnPos)) begin
                    targetPosNext = CurrState;
                    oldPosNext    = drawnPos;
                    colNext       = '0;
                    rowNext       = '0;
                    stateNext     = drawnValid ? StErase : StDraw;
                end
            end
            StErase, StDraw: begin
                if (col == LastCol) begin
                    colNext = '0;
                    if (row == LastRow) begin
                        rowNext = '0;
                        if (state == StErase) begin
                            stateNext = StDraw;
                        end else begin
                            stateNext      = StIdle;
                            drawnPosNext   = targetPos;
                            drawnValidNext = 1'b1;
                        end
                    end else begin
                        rowNext = row + 1'b1;
                    end
                end else begin
                    colNext = col + 1'b1;
                end
            end
            default: stateNext = StIdle;
        endcase
    end

    // Outputs are derived from next-state values so the registered pixel lines up with its state.
    always_comb begin
        plotNext   = (stateNext != StIdle);
        slot       = (stateNext == StErase) ? oldPosNext : targetPosNext;
        xNext      = X;
        yNext      = Y;
        colourNext = Colour;
        if (plotNext) begin
            xNext      = 8'(X_ORIGIN + X_STEP * 32'(slot) + 32'(colNext));
            yNext      = 7'(Y_ROW + 32'(rowNext));
            colourNext = (stateNext == StErase) ? BG_COLOUR : CHAR_COLOUR;
        end
    end

endmodule
